// File: rtl/ms_pkg.sv
// Shared types for the burst master: burst modes and controller states.
package ms_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_WRAP  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ms_if.sv
// Master-side bundle of the beat channel towards a slave.
interface ms_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              clk;
  logic              rst;
  logic              sready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              valid;

  // A beat transfers on any rising edge where valid && sready; the master
  // holds addr/data/valid stable while valid is high and sready is low.
  modport master (
    input  clk,
    input  rst,
    input  sready,
    output addr,
    output data,
    output valid
  );

  modport slave (
    input  clk,
    input  rst,
    output sready,
    input  addr,
    input  data,
    input  valid
  );
endinterface

// File: rtl/ms_addr_gen.sv
// Combinational next-beat address for INCR, FIXED and WRAP bursts.
module ms_addr_gen
  import ms_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int STRIDE    = 1,
  parameter int WRAP_LOG2 = 2
) (
  input  logic [ADDR_W-1:0] addr,
  input  mode_t             mode,
  output logic [ADDR_W-1:0] next_addr
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << WRAP_LOG2) - 1);

  logic [ADDR_W-1:0] incr;

  assign incr = addr + STEP;

  // WRAP keeps the region bits and takes only the low bits of the increment.
  always_comb begin
    unique case (mode)
      MODE_FIXED: next_addr = addr;
      MODE_WRAP:  next_addr = (addr & ~LOW_MASK) | (incr & LOW_MASK);
      default:    next_addr = incr;
    endcase
  end

endmodule

// File: rtl/ms_master_gen.sv
// Burst master: issues len+1 address/data beats with valid/ready flow control
// and a one-cycle done pulse after the last accepted beat.
module ms_master_gen
  import ms_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 4,
  parameter int STRIDE    = 1,
  parameter int DATA_MULT = 4,
  parameter int WRAP_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              sready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
);

  state_t            state;
  mode_t             mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    beat_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              last_beat;

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
    beat_data = DATA_W'(a) * DATA_W'(DATA_MULT);
  endfunction

  ms_addr_gen #(
    .ADDR_W    (ADDR_W),
    .STRIDE    (STRIDE),
    .WRAP_LOG2 (WRAP_LOG2)
  ) u_addr_gen (
    .addr      (addr),
    .mode      (mode_q),
    .next_addr (next_addr)
  );

  assign accept    = valid && sready;
  assign last_beat = (beat_cnt == {1'b0, len_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= MODE_INCR;
      len_q    <= '0;
      beat_cnt <= '0;
      valid    <= 1'b0;
      addr     <= '0;
      data     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q   <= mode_t'(mode);
            len_q    <= len;
            beat_cnt <= '0;
            addr     <= base_addr;
            data     <= beat_data(base_addr);
            valid    <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_beat) begin
              valid <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              addr     <= next_addr;
              data     <= beat_data(next_addr);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_master_gen.sv
// Scoreboarded bench for ms_master_gen: directed bursts, random bursts with
// random back-pressure, and an asynchronous reset abort.
module tb_ms_master_gen;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 4;
  localparam int STRIDE    = 1;
  localparam int DATA_MULT = 4;
  localparam int WRAP_LOG2 = 2;
  localparam int BUDGET    = 300;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              sready;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;

  // Scoreboard entry: {last, addr, data}
  logic [ADDR_W+DATA_W:0] exp_q[$];

  int n_checks;
  int n_fail;
  int beat_cnt;
  int done_cnt;
  int exp_done;
  logic              pend_done;
  logic              prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  ms_master_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .STRIDE    (STRIDE),
    .DATA_MULT (DATA_MULT),
    .WRAP_LOG2 (WRAP_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .len       (len),
    .sready    (sready),
    .valid     (valid),
    .addr      (addr),
    .data      (data),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: closed-form address of beat i.
  function automatic logic [ADDR_W-1:0] model_addr(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                                                   input int i);
    int region;
    int a;
    region = 1 << WRAP_LOG2;
    case (m)
      2'd1:    a = int'(b);
      2'd2:    a = (int'(b) / region) * region + ((int'(b) + i * STRIDE) % region);
      default: a = (int'(b) + i * STRIDE) % (1 << ADDR_W);
    endcase
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
    int d;
    d = (int'(a) * DATA_MULT) % (1 << DATA_W);
    return d[DATA_W-1:0];
  endfunction

  task automatic push_burst(input logic [1:0] m, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i <= int'(l); i++) begin
      a = model_addr(m, b, i);
      exp_q.push_back({(i == int'(l)), a, model_data(a)});
    end
  endtask

  // driver: stall 0 = always ready, 1 = random ready, 2 = low on cycles 1..3
  task automatic run_burst(input logic [1:0] m, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                           input int stall, input bit noise);
    int k;
    int b0;
    bit seen;
    push_burst(m, b, l);
    exp_done++;
    b0 = beat_cnt;
    @(posedge clk); #1;
    start = 1'b1; mode = m; base_addr = b; len = l; sready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (k = 0; k < BUDGET; k++) begin
      if (done) begin
        start = 1'b0;
        seen  = 1'b1;
        break;
      end
      case (stall)
        1:       sready = ($urandom_range(0, 3) != 0);
        2:       sready = !(k >= 1 && k <= 3);
        default: sready = 1'b1;
      endcase
      if (noise) begin
        start     = $urandom_range(0, 1) == 1;
        mode      = 2'($urandom_range(0, 3));
        base_addr = ADDR_W'($urandom);
        len       = LEN_W'($urandom);
      end
      @(posedge clk); #1;
    end
    check("burst_done_seen", 32'(seen), 32'd1);
    check("burst_beats", 32'(beat_cnt - b0), 32'(int'(l) + 1));
    @(posedge clk); #1;
    check("post_busy", 32'(busy), 32'd0);
    check("post_valid", 32'(valid), 32'd0);
    check("post_done", 32'(done), 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W:0] e;
    if (rst) begin
      pend_done  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend_done || done) begin
        check("done_pulse", 32'(done), 32'(pend_done));
        if (done) begin
          check("done_valid_low", 32'(valid), 32'd0);
          check("done_busy_high", 32'(busy), 32'd1);
          done_cnt++;
        end
      end
      pend_done = 1'b0;
      if (prev_stall) begin
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_addr", 32'(addr), 32'(prev_addr));
        check("hold_data", 32'(data), 32'(prev_data));
      end
      if (valid) check("busy_with_valid", 32'(busy), 32'd1);
      prev_stall = valid && !sready;
      prev_addr  = addr;
      prev_data  = data;
      if (valid && sready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", 32'(addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
          check("beat_data", 32'(data), 32'(e[DATA_W-1:0]));
          pend_done = e[ADDR_W+DATA_W];
        end
      end
    end
  end

  initial begin
    int b0;
    n_checks = 0; n_fail = 0; beat_cnt = 0; done_cnt = 0; exp_done = 0;
    pend_done = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    rst = 1'b1; start = 1'b0; mode = 2'd0; base_addr = '0; len = '0; sready = 1'b1;
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_burst(2'd0, 8'h10, 4'd3, 0, 1'b0);
    run_burst(2'd0, 8'h10, 4'd3, 2, 1'b0);
    run_burst(2'd2, 8'h0E, 4'd3, 0, 1'b0);
    run_burst(2'd0, 8'hFE, 4'd3, 0, 1'b0);
    run_burst(2'd1, 8'h20, 4'd2, 0, 1'b1);
    run_burst(2'd3, 8'hFD, 4'd4, 0, 1'b0);
    run_burst(2'd0, 8'h10, 4'd15, 0, 1'b0);
    run_burst(2'd2, 8'h7B, 4'd0, 0, 1'b0);

    // reset between edges part-way through a burst
    push_burst(2'd0, 8'h40, 4'd7);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; base_addr = 8'h40; len = 4'd7; sready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b0 = beat_cnt;
    for (int k = 0; k < BUDGET && (beat_cnt - b0) < 2; k++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_data", 32'(data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("abort_idle_valid", 32'(valid), 32'd0);
    run_burst(2'd0, 8'h33, 4'd5, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      run_burst(2'($urandom_range(0, 3)), ADDR_W'($urandom), LEN_W'($urandom), 1, 1'b1);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_total", 32'(done_cnt), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ms_master_gen.md
MS_MASTER_GEN -- requirements
Module: ms_master_gen

Interface
REQ-001 Parameter ADDR_W, default 8, address width.
REQ-002 Parameter DATA_W, default 16, data width.
REQ-003 Parameter LEN_W, default 4, burst-length field width.
REQ-004 Parameter STRIDE, default 1, address increment per beat.
REQ-005 Parameter DATA_MULT, default 4, data = address * DATA_MULT.
REQ-006 Parameter WRAP_LOG2, default 2, log2 of the WRAP-mode region size.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst  input  1  reset; asynchronous and active-high.
REQ-009 start  input  1  burst request, sampled in IDLE only.
REQ-010 mode  input  2  burst mode: 0 INCR, 1 FIXED, 2 WRAP, 3 reserved.
REQ-011 base_addr  input  ADDR_W  first beat address.
REQ-012 len  input  LEN_W  beats minus one.
REQ-013 sready  input  1  slave ready.
REQ-014 valid  output  1  addr/data valid.
REQ-015 addr  output  ADDR_W  beat address.
REQ-016 data  output  DATA_W  beat data.
REQ-017 busy  output  1  high in RUN and DONE.
REQ-018 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-019 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE on acceptance of the last beat.
- DONE->IDLE unconditionally after one cycle.
REQ-020 On start in IDLE, latch mode, base_addr and len. In the next cycle: valid=1, addr=base_addr, data=(base_addr*DATA_MULT) mod 2^DATA_W.
REQ-021 A beat is accepted when valid && sready are both high in the same cycle.
REQ-022 While valid && !sready, addr, data and valid hold unchanged.
REQ-023 A burst is exactly len+1 accepted beats; len=0 gives a single beat.
REQ-024 On acceptance of a non-last beat, addr advances and data is recomputed from the new addr in the same edge; valid stays high, so there are no bubbles.
REQ-025 Next-address rules:
- INCR: addr+STRIDE mod 2^ADDR_W.
- FIXED: addr unchanged.
- WRAP: upper ADDR_W-WRAP_LOG2 bits held; low WRAP_LOG2 bits = (low bits + STRIDE) mod 2^WRAP_LOG2.
REQ-026 mode 3 behaves as INCR.
REQ-027 valid is low in IDLE and in DONE; done is high only in DONE.
REQ-028 start is ignored while in RUN or DONE; no queuing.
REQ-029 Changes on mode, base_addr and len after latching have no effect on the current burst.
REQ-030 The beat counter is LEN_W+1 bits wide; len at its maximum value yields 2^LEN_W beats with no overflow.

Reset
REQ-031 While rst=1: state=IDLE, and valid, addr, data, busy and done are 0, regardless of clk.
REQ-032 rst mid-burst aborts the burst with no done pulse; the first edge after rst deassertion is in IDLE and accepts start.

Structure
REQ-033 Shared package ms_pkg holds:
- mode enum (MODE_INCR, MODE_FIXED, MODE_WRAP, MODE_RSVD);
- state enum (IDLE, RUN, DONE).
REQ-034 Next-address logic is one combinational sub-module, ms_addr_gen, parameterised by ADDR_W, STRIDE and WRAP_LOG2.
REQ-035 The ms_if master modport carries clk, rst, sready, addr, data and valid.

Verification (ADDR_W=8, DATA_W=16, DATA_MULT=4, STRIDE=1, WRAP_LOG2=2 unless noted)
REQ-036 INCR, base 0x10, len 3, sready=1 -> addr 10,11,12,13 and data 0040,0044,0048,004C on consecutive cycles; done one cycle later; busy low after.
REQ-037 Same burst with sready low 3 cycles at beat 2 -> addr 0x11 and data 0x0044 held 3 cycles, valid stays high; beat total still 4.
REQ-038 WRAP, base 0x0E, len 3 -> addr 0E,0F,0C,0D. INCR, base 0xFE, len 3 -> FE,FF,00,01 with data 03F8,03FC,0000,0004.
REQ-039 FIXED, base 0x20, len 2, with start pulsed again during RUN -> addr 20,20,20, exactly one done, and the second start ignored.
REQ-040 rst asserted between clk edges at beat 2 -> all outputs 0 immediately, no done; start after release runs a full new burst.
REQ-041 len 15, sready=1 -> 16 beats, addr 0x10..0x1F, single done.
